inst_fetch_queue: RTL and testbench

Instruction-fetch queue sitting directly downstream of the PC register in the ifetch stage. It takes the fetch PC, issues requests on the SRAM-like instruction bus, and tracks outstanding responses in order. It buffers returned instructions with their PCs in a small FIFO and hands them to decode through a valid/ready handshake. Flush (branch redirect / exception) discards buffered entries and silently drops responses still in flight.

---
 rtl/inst_fetch_queue_if.sv | 27 ++
 rtl/inst_fetch_queue.sv | 122 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue signal bundle: PC-stage handshake, SRAM-like instruction bus, decode handshake and flush.
interface inst_fetch_queue_if;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        fetch_accept;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_adel;

   modport master (
      input  fetch_pc, fetch_valid, inst_addr_ok, inst_data_ok, inst_rdata, flush, id_ready,
      output fetch_accept, inst_req, inst_addr, id_valid, id_pc, id_inst, id_adel
   );

   modport slave (
      output fetch_pc, fetch_valid, inst_addr_ok, inst_data_ok, inst_rdata, flush, id_ready,
      input  fetch_accept, inst_req, inst_addr, id_valid, id_pc, id_inst, id_adel
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// In-order fetch queue: issues PCs to the instruction bus and buffers responses for decode; data_ok in N -> id_valid in N+1.
// Backpressure: inst_req/fetch_accept held low while buffered + in-flight + to-be-discarded responses fill DEPTH credits.
module inst_fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   inst_fetch_queue_if.master ifq
);
   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW+1:0] DEPTH_W = DEPTH[AW+1:0];

   typedef logic [AW:0]   ptr_t;
   typedef logic [AW-1:0] idx_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
      logic        filled;
   } entry_t;

   entry_t ent_q [DEPTH];
   ptr_t   alloc_ptr;
   ptr_t   fill_ptr;
   ptr_t   rd_ptr;
   ptr_t   discard;

   ptr_t          used;
   ptr_t          in_flight;
   logic [AW+1:0] occupancy;
   logic          credit;
   logic          aligned;
   logic          hs;
   logic          mis_acc;
   logic          drop;
   logic          fill;
   logic          pop;
   idx_t          alloc_idx;
   idx_t          fill_idx;
   idx_t          rd_idx;
   entry_t        head;

   assign used      = alloc_ptr - rd_ptr;
   assign in_flight = alloc_ptr - fill_ptr;
   assign occupancy = {1'b0, used} + {1'b0, discard};
   assign credit    = occupancy < DEPTH_W;

   assign alloc_idx = alloc_ptr[AW-1:0];
   assign fill_idx  = fill_ptr[AW-1:0];
   assign rd_idx    = rd_ptr[AW-1:0];

   assign aligned        = ifq.fetch_pc[1:0] == 2'b00;
   assign ifq.inst_req   = ifq.fetch_valid & aligned & credit & ~ifq.flush;
   assign ifq.inst_addr  = ifq.fetch_pc;
   assign hs             = ifq.inst_req & ifq.inst_addr_ok;

   // A misaligned PC bypasses the bus, so it may only enter once everything ahead of it has its data.
   assign mis_acc = ifq.fetch_valid & ~aligned & credit & ~ifq.flush
                  & (fill_ptr == alloc_ptr) & (discard == '0);
   assign ifq.fetch_accept = hs | mis_acc;

   // Responses owed to pre-flush requests are always older, so they are drained first.
   // A same-cycle handshake counts as outstanding: the bus may answer in the request cycle.
   assign drop = ifq.inst_data_ok & (discard != '0);
   assign fill = ifq.inst_data_ok & (discard == '0) & ((in_flight != '0) | hs);

   assign head         = ent_q[rd_idx];
   assign ifq.id_valid = (used != '0) & head.filled;
   assign ifq.id_pc    = head.pc;
   assign ifq.id_inst  = head.inst;
   assign ifq.id_adel  = head.adel;
   assign pop          = ifq.id_valid & ifq.id_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         rd_ptr    <= '0;
         discard   <= '0;
      end else if (ifq.flush) begin
         // Unfilled entries become debt; a same-cycle response has already paid one off.
         discard  <= discard + in_flight - {{AW{1'b0}}, drop | fill};
         fill_ptr <= alloc_ptr;
         rd_ptr   <= alloc_ptr;
      end else begin
         if (hs) begin
            ent_q[alloc_idx].pc     <= ifq.fetch_pc;
            ent_q[alloc_idx].inst   <= '0;
            ent_q[alloc_idx].adel   <= 1'b0;
            ent_q[alloc_idx].filled <= 1'b0;
            alloc_ptr               <= alloc_ptr + 1'b1;
         end else if (mis_acc) begin
            ent_q[alloc_idx].pc     <= ifq.fetch_pc;
            ent_q[alloc_idx].inst   <= '0;
            ent_q[alloc_idx].adel   <= 1'b1;
            ent_q[alloc_idx].filled <= 1'b1;
            alloc_ptr               <= alloc_ptr + 1'b1;
         end

         // Placed after the allocation so a same-cycle fill of the new entry wins on inst/filled.
         if (fill) begin
            ent_q[fill_idx].inst   <= ifq.inst_rdata;
            ent_q[fill_idx].filled <= 1'b1;
            fill_ptr               <= fill_ptr + 1'b1;
         end else if (mis_acc) begin
            fill_ptr <= fill_ptr + 1'b1;
         end

         if (drop) begin
            discard <= discard - 1'b1;
         end

         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic, all checked against a queue-based model.
module tb_inst_fetch_queue;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
      logic        filled;
   } ent_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inst_fetch_queue_if ifq ();
   inst_fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .ifq(ifq));

   // Model: entries in program order, outstanding debt to discard, and bus responses owed in order.
   ent_t        mq[$];
   logic [31:0] bq[$];
   int          mdisc = 0;
   logic [31:0] next_data;

   int total  = 0;
   int bad    = 0;
   int hs_cnt = 0;
   logic        last_acc, last_req, last_idv, last_adel;
   logic [31:0] last_pc, last_inst;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step(input logic fv, input logic [31:0] pc, input logic aok,
                       input logic dok, input logic fl, input logic rdy);
      int          unfilled;
      logic        credit, aligned, all_filled, e_req, e_hs, e_mis, e_idv, d_ok, found;
      logic [31:0] rdata;
      ent_t        e;
      @(negedge clk);
      ifq.fetch_valid  = fv;
      ifq.fetch_pc     = pc;
      ifq.inst_addr_ok = aok;
      ifq.flush        = fl;
      ifq.id_ready     = rdy;
      ifq.inst_data_ok = 1'b0;
      #1;
      // Bus model: answers only what it owes, possibly the request it is accepting right now.
      d_ok  = dok && (bq.size() > 0 || (ifq.inst_req && aok));
      rdata = (bq.size() > 0) ? bq[0] : next_data;
      ifq.inst_data_ok = d_ok;
      ifq.inst_rdata   = d_ok ? rdata : $urandom;
      #1;
      unfilled = 0;
      foreach (mq[i]) if (!mq[i].filled) unfilled++;
      credit     = (mq.size() + mdisc) < DEPTH;
      aligned    = (pc[1:0] == 2'b00);
      all_filled = (unfilled == 0) && (mdisc == 0);
      e_req      = fv && aligned && credit && !fl;
      e_hs       = e_req && aok;
      e_mis      = fv && !aligned && credit && !fl && all_filled;
      e_idv      = (mq.size() > 0) && mq[0].filled;
      check_eq("inst_req", ifq.inst_req, e_req);
      check_eq("fetch_accept", ifq.fetch_accept, e_hs | e_mis);
      if (e_req) check_eq("inst_addr", ifq.inst_addr, pc);
      check_eq("id_valid", ifq.id_valid, e_idv);
      if (e_idv) begin
         check_eq("id_pc", ifq.id_pc, mq[0].pc);
         check_eq("id_inst", ifq.id_inst, mq[0].inst);
         check_eq("id_adel", ifq.id_adel, mq[0].adel);
      end
      last_acc  = ifq.fetch_accept;
      last_req  = ifq.inst_req;
      last_idv  = ifq.id_valid;
      last_pc   = ifq.id_pc;
      last_inst = ifq.id_inst;
      last_adel = ifq.id_adel;

      if (e_idv && rdy && !fl) void'(mq.pop_front());
      if (e_hs) begin
         hs_cnt++;
         bq.push_back(next_data);
         next_data = $urandom;
         e = '{pc: pc, inst: 32'h0, adel: 1'b0, filled: 1'b0};
         mq.push_back(e);
      end
      if (e_mis) begin
         e = '{pc: pc, inst: 32'h0, adel: 1'b1, filled: 1'b1};
         mq.push_back(e);
      end
      if (d_ok && bq.size() > 0) begin
         rdata = bq.pop_front();
         if (mdisc > 0) begin
            mdisc--;
         end else begin
            found = 1'b0;
            foreach (mq[i]) begin
               if (!found && !mq[i].filled) begin
                  mq[i].inst   = rdata;
                  mq[i].filled = 1'b1;
                  found        = 1'b1;
               end
            end
         end
      end
      if (fl) begin
         foreach (mq[i]) if (!mq[i].filled) mdisc++;
         mq.delete();
      end
   endtask

   task automatic drain();
      repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cur_pc, bp_pc, r;
      logic        fv, fl, rdy;
      next_data        = $urandom;
      ifq.fetch_valid  = 1'b0;
      ifq.fetch_pc     = 32'h0;
      ifq.inst_addr_ok = 1'b0;
      ifq.inst_data_ok = 1'b0;
      ifq.inst_rdata   = 32'h0;
      ifq.flush        = 1'b0;
      ifq.id_ready     = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_id_valid", ifq.id_valid, 0);
      check_eq("rst_id_pc", ifq.id_pc, 0);
      check_eq("rst_id_inst", ifq.id_inst, 0);
      check_eq("rst_id_adel", ifq.id_adel, 0);
      check_eq("rst_inst_req", ifq.inst_req, 0);
      check_eq("rst_fetch_accept", ifq.fetch_accept, 0);
      rst_n = 1'b1;

      // Streaming: one instruction per cycle, visible one cycle after its request
      for (int i = 0; i < 6; i++) begin
         step(i < 4, 32'hBFC0_0000 + 32'(4 * i), 1'b1, 1'b1, 1'b0, 1'b1);
         if (i >= 1 && i <= 4) begin
            check_eq("stream_valid", last_idv, 1);
            check_eq("stream_pc", last_pc, 32'hBFC0_0000 + 32'(4 * (i - 1)));
         end else begin
            check_eq("stream_idle", last_idv, 0);
         end
      end
      drain();

      // Backpressure: DEPTH handshakes, then stall until decode drains
      hs_cnt = 0;
      bp_pc  = 32'h0000_9000;
      repeat (6) begin
         step(1'b1, bp_pc, 1'b1, 1'b1, 1'b0, 1'b0);
         if (last_acc) bp_pc += 4;
      end
      check_eq("bp_handshakes", hs_cnt, DEPTH);
      check_eq("bp_req_stalled", last_req, 0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
         check_eq("bp_drain_pc", last_pc, 32'h0000_9000 + 32'(4 * i));
      end
      step(1'b1, bp_pc, 1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("bp_resume_req", last_req, 1);
      drain();

      // Flush with three responses in flight
      for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_1000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("flush_new_accept", last_acc, 1);
      for (int k = 1; k <= 5; k++) begin
         step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
         if (k < 5) check_eq("flush_dropped", last_idv, 0);
         else begin
            check_eq("flush_after_valid", last_idv, 1);
            check_eq("flush_after_pc", last_pc, 32'h8000_0000);
         end
      end
      drain();

      // Misaligned PC waits behind an outstanding aligned fetch
      step(1'b1, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (2) begin
         step(1'b1, 32'hBFC0_0002, 1'b0, 1'b0, 1'b0, 1'b1);
         check_eq("mis_wait_accept", last_acc, 0);
         check_eq("mis_wait_req", last_req, 0);
      end
      step(1'b1, 32'hBFC0_0002, 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("mis_fill_cycle_accept", last_acc, 0);
      step(1'b1, 32'hBFC0_0002, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("mis_accept", last_acc, 1);
      check_eq("mis_no_req", last_req, 0);
      check_eq("mis_head_pc", last_pc, 32'h0000_2000);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("mis_valid", last_idv, 1);
      check_eq("mis_pc", last_pc, 32'hBFC0_0002);
      check_eq("mis_adel", last_adel, 1);
      check_eq("mis_inst", last_inst, 0);
      drain();

      // Pop, fill and handshake in one cycle
      step(1'b1, 32'h0000_3000, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h0000_3004, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0000_3008, 1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("sim_pop_pc", last_pc, 32'h0000_3000);
      check_eq("sim_accept", last_acc, 1);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("sim_next_pc", last_pc, 32'h0000_3004);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("sim_last_pc", last_pc, 32'h0000_3008);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("sim_empty", last_idv, 0);

      // Reset with two responses outstanding
      step(1'b1, 32'h0000_4000, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0000_4004, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      ifq.fetch_valid  = 1'b0;
      ifq.inst_data_ok = 1'b0;
      ifq.flush        = 1'b0;
      rst_n            = 1'b0;
      #1;
      check_eq("mid_rst_id_valid", ifq.id_valid, 0);
      check_eq("mid_rst_inst_req", ifq.inst_req, 0);
      check_eq("mid_rst_alloc_ptr", 32'(dut.alloc_ptr), 0);
      check_eq("mid_rst_fill_ptr", 32'(dut.fill_ptr), 0);
      check_eq("mid_rst_rd_ptr", 32'(dut.rd_ptr), 0);
      check_eq("mid_rst_discard", 32'(dut.discard), 0);
      mq.delete();
      bq.delete();
      mdisc = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic with a PC stage that follows fetch_accept
      cur_pc = 32'hBFC0_0000;
      for (int c = 0; c < 3000; c++) begin
         fv  = $urandom_range(0, 99) < 85;
         fl  = $urandom_range(0, 39) == 0;
         rdy = ((c % 200) < 40) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
         step(fv, cur_pc, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, fl, rdy);
         if (fl) begin
            r      = $urandom;
            cur_pc = r & 32'hFFFF_FFFC;
         end else if (last_acc) begin
            if ($urandom_range(0, 15) == 0) begin
               r      = $urandom;
               cur_pc = (r & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            end else begin
               cur_pc = (cur_pc & 32'hFFFF_FFFC) + 32'd4;
            end
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
